// File: rtl/uart_reg_master.sv
// Byte-stream command engine: decodes read/write commands from the UART receiver,
// drives the register bank CPU port and returns ack or read-data bytes to the transmitter.
module uart_reg_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_COUNT      = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [7:0]                      rx_data_i,
    input  logic                            rx_valid_i,
    output logic [7:0]                      tx_data_o,
    output logic                            tx_valid_o,
    input  logic                            tx_ready_i,
    output logic [ADDR_WIDTH-1:0]           addr_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            wr_en_cpu_o,
    output logic                            rd_en_cpu_o,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] reg_data_i,
    output logic                            rx_drop_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, ACCESS, RESP} state_e;

    typedef struct packed {
        logic is_wr;
        logic err;
    } cmd_t;

    state_e                state_q, state_d;
    cmd_t                  cmd_q;
    logic [CW-1:0]         cnt_q;
    logic [TW-1:0]         tmo_q;
    logic [DATA_WIDTH-1:0] resp_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            cmd_addr;
    logic                  cmd_err;
    logic [CW-1:0]         resp_last;
    logic                  hs;

    always_comb begin
        cmd_addr = rx_data_i & 8'((1 << ADDR_WIDTH) - 1);
        cmd_err  = (((rx_data_i & 8'h7F) >> ADDR_WIDTH) != 8'h00) ||
                   (cmd_addr >= 8'(REG_COUNT));
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < REG_COUNT; k++)
            if (addr_o == ADDR_WIDTH'(k))
                rd_word = reg_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Acks and errors are a single byte; only successful reads return a full word.
    assign resp_last = (cmd_q.is_wr || cmd_q.err) ? '0 : CW'(NB - 1);
    assign hs        = tx_valid_o && tx_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        wr_en_cpu_o = 1'b0;
        rd_en_cpu_o = 1'b0;
        rx_drop_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid_i) state_d = rx_data_i[7] ? COLLECT : ACCESS;
            end
            COLLECT: begin
                if (rx_valid_i) begin
                    if (cnt_q == CW'(NB - 1)) state_d = ACCESS;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                wr_en_cpu_o = cmd_q.is_wr && !cmd_q.err;
                rd_en_cpu_o = !cmd_q.is_wr && !cmd_q.err;
                rx_drop_o   = rx_valid_i;
                state_d     = RESP;
            end
            RESP: begin
                rx_drop_o = rx_valid_i;
                if (hs && cnt_q == resp_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            resp_q     <= '0;
            tx_valid_o <= 1'b0;
            addr_o     <= '0;
            data_o     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid_i) begin
                        addr_o      <= cmd_addr[ADDR_WIDTH-1:0];
                        cmd_q.is_wr <= rx_data_i[7];
                        cmd_q.err   <= cmd_err;
                        cnt_q       <= '0;
                        tmo_q       <= '0;
                    end
                end
                COLLECT: begin
                    if (rx_valid_i) begin
                        // Little-endian: each byte enters at the top, first byte ends at [7:0].
                        data_o <= (data_o >> 8) | (DATA_WIDTH'(rx_data_i) << (DATA_WIDTH - 8));
                        cnt_q  <= (cnt_q == CW'(NB - 1)) ? '0 : cnt_q + 1'b1;
                        tmo_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ACCESS: begin
                    cnt_q      <= '0;
                    tx_valid_o <= 1'b1;
                    if (cmd_q.err)        resp_q <= DATA_WIDTH'(8'hEE);
                    else if (cmd_q.is_wr) resp_q <= DATA_WIDTH'(8'hA5);
                    else                  resp_q <= rd_word;
                end
                RESP: begin
                    if (hs) begin
                        resp_q <= resp_q >> 8;
                        if (cnt_q == resp_last) tx_valid_o <= 1'b0;
                        else                    cnt_q      <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data_o = resp_q[7:0];

endmodule

// File: doc/uart_reg_master.md
# uart_reg_master

Byte-stream command engine that lets a host on the far side of the UART link read and write the UART register bank. It consumes received bytes from the UART receiver, decodes read/write commands, drives the register bank's CPU-side access port (address, write data, write/read enables), and returns acknowledge or read-data bytes to the UART transmitter. It is the initiator for the register bank's CPU port.

## Interface
Parameters:
- ADDR_WIDTH, 2, register address width; must be ≤ 7.
- DATA_WIDTH, 32, register width; must be a multiple of 8. NB = DATA_WIDTH/8 bytes per word.
- REG_COUNT, 4, number of implemented registers; must be ≤ 2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes of a write before abort; must be ≥ 1.

Ports:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_ni  in  1  asynchronous, active-low reset.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe: rx_data_i valid.
- tx_data_o  out  8  byte to transmit.
- tx_valid_o  out  1  tx_data_o valid; held until accepted.
- tx_ready_i  in  1  transmitter accepts byte when tx_valid_o && tx_ready_i.
- addr_o  out  ADDR_WIDTH  register address to bank.
- data_o  out  DATA_WIDTH  write data to bank.
- wr_en_cpu_o  out  1  one-cycle register write strobe.
- rd_en_cpu_o  out  1  one-cycle register read strobe.
- reg_data_i  in  REG_COUNT*DATA_WIDTH  flattened register contents from bank; register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- rx_drop_o  out  1  one-cycle pulse: received byte discarded.

## Operation
- Command byte: bit7 = 1 write, 0 read; bits[ADDR_WIDTH-1:0] = address; bits[6:ADDR_WIDTH] must be 0.
- Write: command followed by NB data bytes, little-endian (first byte → data[7:0]). Response one byte: 0xA5 on success, 0xEE on error.
- Read: command only. Response NB bytes of register value, LSB first, or single 0xEE on error.
- Error: address ≥ REG_COUNT or non-zero reserved bits. No wr_en/rd_en is issued on error. An erroneous write command still consumes its NB data bytes before 0xEE is sent.
- States: IDLE → (write cmd) COLLECT → ACCESS → RESP → IDLE; IDLE → (read cmd) ACCESS → RESP → IDLE. Error commands traverse the same path with ACCESS issuing no strobe.
- COLLECT: byte counter 0..NB-1; shifts bytes into data register; after byte NB-1 → ACCESS.
- ACCESS: exactly one cycle; asserts wr_en_cpu_o (write) or rd_en_cpu_o (read) with addr_o/data_o stable; read captures reg_data_i slice for addr_o in that same cycle.
- RESP: sends response bytes via valid/ready; byte counter advances on each handshake; after last handshake → IDLE.
- Timeout: in COLLECT, counter resets on each rx_valid_i; reaching TIMEOUT_CYCLES with no byte → IDLE, no access, no response.
- Bytes arriving in ACCESS or RESP are discarded and pulse rx_drop_o that cycle. No bytes are dropped in IDLE or COLLECT.
- addr_o and data_o hold their last values between commands.

## Timing
- Reset values: tx_data_o 0x00, tx_valid_o 0, addr_o 0, data_o 0, wr_en_cpu_o 0, rd_en_cpu_o 0, rx_drop_o 0; state IDLE, all counters 0. Reset mid-command aborts it with no strobe or response.
- Read: command strobe at cycle N → rd_en_cpu_o high in N+1 → tx_valid_o high with byte0 from N+2.
- Write: last data byte strobe at cycle M → wr_en_cpu_o high in M+1 → tx_valid_o with 0xA5 from M+2.
- Error read: command at N → ACCESS (no strobe) at N+1 → 0xEE valid from N+2.
- tx_data_o must not change while tx_valid_o && !tx_ready_i. After a handshake at cycle T, the next response byte is valid in T+1; tx_valid_o drops in T+1 after the final byte.
- tx_ready_i held high: an NB-byte read response completes in NB consecutive cycles.
- Timeout abort occurs exactly TIMEOUT_CYCLES cycles after the last accepted byte.
- Back-to-back: the next command byte is accepted in the cycle after RESP returns to IDLE.

## Test plan
- Write 0x81, 0x78, 0x56, 0x34, 0x12 (DATA_WIDTH 32) -> one-cycle wr_en_cpu_o with addr_o=1, data_o=0x12345678; then tx 0xA5.
- Read 0x02 with register 2 = 0xDEADBEEF -> one-cycle rd_en_cpu_o with addr_o=2; tx bytes EF, BE, AD, DE in order.
- Read 0x10 (reserved bit set), and read of address 3 with REG_COUNT=3 -> no strobes; single tx 0xEE each.
- Read with tx_ready_i low for 5 cycles per byte -> tx_data_o stable while stalled; bytes in order. A byte sent during RESP -> rx_drop_o pulse, result unaffected.
- Write cmd + 2 data bytes, then silence for TIMEOUT_CYCLES -> return to IDLE, no wr_en_cpu_o, no tx. A following read completes normally.
- rst_ni asserted mid-COLLECT -> all outputs at reset values asynchronously. After release, a fresh write succeeds.
